// File: rtl/cla_adder_pipe_if.sv
// Handshake and operand/result bus for the pipelined CLA adder/subtractor.
// The in_sat lane exists only when CLA_SAT_EN is defined.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
`ifdef CLA_SAT_EN
    logic             in_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    // Producer/consumer side (drives operands, takes results)
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub,
`ifdef CLA_SAT_EN
        output in_sat,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    // Adder side
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub,
`ifdef CLA_SAT_EN
        input  in_sat,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Carry-pipelined carry-lookahead adder/subtractor.
// WIDTH bits are split into STAGES segments of SEG bits; each stage resolves one
// segment with BLOCK-bit lookahead groups and registers the carry for the next.
// Optional feature macro: CLA_SAT_EN (adds in_sat, signed saturation on overflow).
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input logic            clk,
    input logic            rst,
    cla_adder_pipe_if.slave bus
);
    localparam int STG_DIV = (STAGES > 0) ? STAGES : 1;
    localparam int SEG     = WIDTH / STG_DIV;
    localparam int BLK_DIV = (BLOCK > 0) ? BLOCK : 1;
    localparam int NBLK    = SEG / BLK_DIV;

    if (STAGES < 1 || STAGES > 8 || BLOCK < 1 || (WIDTH % STG_DIV) != 0 ||
        (SEG % BLK_DIV) != 0) begin : g_param_check
        $error("cla_adder_pipe: illegal WIDTH/STAGES/BLOCK combination");
    end

    // One SEG-bit CLA: returns {carry out, carry into segment MSB, sum}
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           pre_g;
        logic           pre_p;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int blk = 0; blk < NBLK; blk++) begin
            pre_g = 1'b0;
            pre_p = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                pre_g = g[blk*BLOCK+i] | (p[blk*BLOCK+i] & pre_g);
                pre_p = pre_p & p[blk*BLOCK+i];
                c[blk*BLOCK+i+1] = pre_g | (pre_p & c[blk*BLOCK]);
            end
        end
        return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
    endfunction

    logic             advance;
    logic             src_valid [STAGES];
    logic [WIDTH-1:0] src_a     [STAGES];
    logic [WIDTH-1:0] src_b     [STAGES];
    logic [WIDTH-1:0] src_sum   [STAGES];
    logic             src_c     [STAGES];
    logic [WIDTH-1:0] res_sum   [STAGES];
    logic             res_cout  [STAGES];
    logic             last_cmsb;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_ovf;

    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             c_q     [STAGES];
    logic             c_d     [STAGES];
`ifdef CLA_SAT_EN
    logic             src_sat [STAGES];
    logic             sat_q   [STAGES];
    logic             sat_d   [STAGES];
`endif
    logic [WIDTH-1:0] out_sum_q;
    logic [WIDTH-1:0] out_sum_d;
    logic             out_cout_q;
    logic             out_cout_d;
    logic             out_ovf_q;
    logic             out_ovf_d;
    logic             out_zero_q;
    logic             out_zero_d;

    assign advance       = ~valid_q[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;

    // Select each stage's operands: stage 0 from the bus, later stages from the previous register
    always_comb begin
        src_valid[0] = bus.in_valid;
        src_a[0]     = bus.in_a;
        src_b[0]     = bus.in_sub ? ~bus.in_b : bus.in_b;
        src_c[0]     = bus.in_sub | bus.in_cin;
        src_sum[0]   = '0;
`ifdef CLA_SAT_EN
        src_sat[0]   = bus.in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_c[k]     = c_q[k-1];
            src_sum[k]   = sum_q[k-1];
`ifdef CLA_SAT_EN
            src_sat[k]   = sat_q[k-1];
`endif
        end
    end

    // Resolve segment k in stage k and merge it into the travelling partial sum
    always_comb begin : stage_eval
        logic [SEG+1:0] seg_res;
        seg_res   = '0;
        last_cmsb = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            seg_res     = cla_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
            res_sum[k]  = src_sum[k];
            res_sum[k][k*SEG +: SEG] = seg_res[SEG-1:0];
            res_cout[k] = seg_res[SEG+1];
            if (k == STAGES - 1) begin
                last_cmsb = seg_res[SEG];
            end
        end
    end

    // Final result of the last stage: overflow flag and optional saturation clamp
    always_comb begin
        fin_sum = res_sum[STAGES-1];
        fin_ovf = last_cmsb ^ res_cout[STAGES-1];
`ifdef CLA_SAT_EN
        if (src_sat[STAGES-1] && fin_ovf) begin
            fin_sum = fin_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Next state: everything shifts together on advance, otherwise holds
    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        c_d        = c_q;
`ifdef CLA_SAT_EN
        sat_d      = sat_q;
`endif
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_d[k] = src_valid[k];
                a_d[k]     = src_a[k];
                b_d[k]     = src_b[k];
                sum_d[k]   = res_sum[k];
                c_d[k]     = res_cout[k];
`ifdef CLA_SAT_EN
                sat_d[k]   = src_sat[k];
`endif
            end
            if (src_valid[STAGES-1]) begin
                out_sum_d  = fin_sum;
                out_cout_d = res_cout[STAGES-1];
                out_ovf_d  = fin_ovf;
                out_zero_d = (fin_sum == '0);
            end
        end
    end

    // Pipeline and output registers; reset drops every in-flight beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                c_q[k]     <= 1'b0;
`ifdef CLA_SAT_EN
                sat_q[k]   <= 1'b0;
`endif
            end
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            c_q        <= c_d;
`ifdef CLA_SAT_EN
            sat_q      <= sat_d;
`endif
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
            out_ovf_q  <= out_ovf_d;
            out_zero_q <= out_zero_d;
        end
    end
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed corner beats, mid-stream
// reset, and randomized traffic with random backpressure against an
// arithmetic reference model with a queue of expected results.
module tb_cla_adder_pipe #(
    parameter int STAGES = 2
);
    localparam int WIDTH = 32;
    localparam int BLOCK = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               age;
    } expect_t;

    logic    clk;
    logic    rst;
    expect_t expQ[$];
    int      checkCount;
    int      missCount;
    int      accepted;
    int      target;
    int      guard;

    cla_adder_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_adder_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .BLOCK (BLOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic expect_t refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input bit cin, input bit sub, input bit sat);
        expect_t         r;
        longint          sa;
        longint          sb;
        longint          sres;
        longint          maxPos;
        longint          minNeg;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ures;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        ua     = {32'd0, a};
        ub     = {32'd0, b};
        maxPos = (longint'(1) <<< (WIDTH - 1)) - 1;
        minNeg = -maxPos - 1;
        if (sub) begin
            sres   = sa - sb;
            ures   = ua - ub;
            r.cout = (ua >= ub);
        end else begin
            sres   = sa + sb + longint'(cin);
            ures   = ua + ub + {63'd0, cin};
            r.cout = ures[WIDTH];
        end
        r.sum = ures[WIDTH-1:0];
        r.ovf = (sres > maxPos) || (sres < minNeg);
        if (sat && r.ovf) begin
            r.sum = (sres > 0) ? maxPos[WIDTH-1:0] : minNeg[WIDTH-1:0];
        end
        r.zero = (r.sum == '0);
        r.age  = 0;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] randOperand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // One clock cycle: check outputs against the model, drive a beat, update the model
    task automatic applyStimulus(input bit inV, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input bit cin, input bit sub,
                                 input bit sat, input bit outR);
        bit      expValid;
        bit      expAdvance;
        bit      satEff;
        expect_t e;
        @(negedge clk);
        expValid   = (expQ.size() > 0) && (expQ[0].age >= STAGES);
        expAdvance = !expValid || outR;
        checkOutput("out_valid", bus.out_valid, expValid);
        satEff       = 1'b0;
        bus.in_valid = inV;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
`ifdef CLA_SAT_EN
        bus.in_sat   = sat;
        satEff       = sat;
`endif
        bus.out_ready = outR;
        #1;
        checkOutput("in_ready", bus.in_ready, expAdvance);
        if (expValid) begin
            e = expQ[0];
            checkOutput(outR ? "sum" : "stall_sum", bus.out_sum, e.sum);
            checkOutput(outR ? "cout" : "stall_cout", bus.out_cout, e.cout);
            checkOutput(outR ? "ovf" : "stall_ovf", bus.out_ovf, e.ovf);
            checkOutput(outR ? "zero" : "stall_zero", bus.out_zero, e.zero);
            if (outR) begin
                void'(expQ.pop_front());
            end
        end
        if (expAdvance) begin
            for (int i = 0; i < expQ.size(); i++) begin
                expQ[i].age = expQ[i].age + 1;
            end
            if (inV) begin
                e     = refModel(a, b, cin, sub, satEff);
                e.age = 1;
                expQ.push_back(e);
                accepted++;
            end
        end
    endtask

    task automatic drainPipe();
        for (int i = 0; i < STAGES + 4 && expQ.size() > 0; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    initial begin
        checkCount    = 0;
        missCount     = 0;
        accepted      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
`ifdef CLA_SAT_EN
        bus.in_sat    = 1'b0;
`endif
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_sum", bus.out_sum, '0);
        checkOutput("rst_out_cout", bus.out_cout, 1'b0);
        checkOutput("rst_out_ovf", bus.out_ovf, 1'b0);
        checkOutput("rst_out_zero", bus.out_zero, 1'b0);
        checkOutput("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        $display("[TB] directed corner beats");
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        drainPipe();

        $display("[TB] reset with beats in flight");
        applyStimulus(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", bus.out_valid, 1'b0);
        checkOutput("midrst_out_sum", bus.out_sum, '0);
        checkOutput("midrst_out_cout", bus.out_cout, 1'b0);
        checkOutput("midrst_out_ovf", bus.out_ovf, 1'b0);
        checkOutput("midrst_out_zero", bus.out_zero, 1'b0);
        expQ.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (STAGES + 3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic with backpressure");
        target = accepted + 100;
        guard  = 0;
        while (accepted < target && guard < 3000) begin
            applyStimulus($urandom_range(0, 3) != 0, randOperand(), randOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            guard++;
        end
        checkOutput("beats_accepted", accepted, target);
        drainPipe();
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end
endmodule
